inst_decode_queue: RTL and testbench

- Parametrised instruction buffer between IF and the decoders; successor to the single-issue IF→ID hand-off.
- Accepts up to FETCH_WIDTH instructions per cycle with their PC and branch-prediction info, and stores them in a circular FIFO.
- Presents up to DECODE_WIDTH oldest entries per cycle to parallel decoder instances.
- Supports a pipeline flush on misprediction or exception redirect.

---
 rtl/inst_decode_queue_pkg.sv | 20 ++
 rtl/dq_prefix_count.sv | 18 +
 rtl/inst_decode_queue.sv | 100 ++++++++++
 tb/tb_inst_decode_queue.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_decode_queue_pkg.sv
// inst_decode_queue_pkg: default entry field widths and packed entry layout for the decode queue.
package inst_decode_queue_pkg;
  localparam int DQ_ADDR_WIDTH = 32;
  localparam int DQ_INST_WIDTH = 32;
  localparam int DQ_GHR_WIDTH = 5;
  localparam int DQ_ENTRY_WIDTH = DQ_ADDR_WIDTH + DQ_INST_WIDTH + 1 + DQ_GHR_WIDTH;
  // Packed entry is {pc, inst, taken, pht_index} from MSB to LSB.
  function automatic int dq_entry_width(input int aw, input int iw, input int gw);
    return aw + iw + 1 + gw;
  endfunction
  function automatic int dq_taken_bit(input int gw);
    return gw;
  endfunction
  function automatic int dq_inst_lsb(input int gw);
    return gw + 1;
  endfunction
  function automatic int dq_pc_lsb(input int iw, input int gw);
    return gw + 1 + iw;
  endfunction
endpackage

// File: rtl/dq_prefix_count.sv
// dq_prefix_count: length of the contiguous run of ones starting at bit 0.
module dq_prefix_count #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0]             vec,
  output logic [$clog2(WIDTH+1)-1:0]   cnt
);
  localparam int CW = $clog2(WIDTH + 1);
  logic run;
  always_comb begin
    cnt = '0;
    run = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      run = run & vec[i];
      cnt = cnt + CW'(run);
    end
  end
endmodule

// File: rtl/inst_decode_queue.sv
// inst_decode_queue: circular IF->decode instruction buffer, FETCH_WIDTH in / DECODE_WIDTH out per cycle.
// Optional same-cycle empty-queue bypass enabled by defining DECODE_QUEUE_BYPASS_EN.
module inst_decode_queue
  import inst_decode_queue_pkg::*;
#(
  parameter int FETCH_WIDTH  = 2,
  parameter int DECODE_WIDTH = 2,
  parameter int DEPTH        = 8,
  parameter int ADDR_WIDTH   = DQ_ADDR_WIDTH,
  parameter int INST_WIDTH   = DQ_INST_WIDTH,
  parameter int GHR_WIDTH    = DQ_GHR_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic [FETCH_WIDTH-1:0]                 in_valid,
  input  logic [FETCH_WIDTH*ADDR_WIDTH-1:0]      in_pc,
  input  logic [FETCH_WIDTH*INST_WIDTH-1:0]      in_inst,
  input  logic [FETCH_WIDTH-1:0]                 in_taken,
  input  logic [FETCH_WIDTH*GHR_WIDTH-1:0]       in_pht_index,
  output logic                                   in_ready,
  output logic [DECODE_WIDTH-1:0]                out_valid,
  output logic [DECODE_WIDTH*ADDR_WIDTH-1:0]     out_pc,
  output logic [DECODE_WIDTH*INST_WIDTH-1:0]     out_inst,
  output logic [DECODE_WIDTH-1:0]                out_taken,
  output logic [DECODE_WIDTH*GHR_WIDTH-1:0]      out_pht_index,
  input  logic [$clog2(DECODE_WIDTH+1)-1:0]      out_accept,
  output logic [$clog2(DEPTH+1)-1:0]             count
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int NI_W = $clog2(FETCH_WIDTH + 1);
  localparam int NO_W = $clog2(DECODE_WIDTH + 1);
  localparam int EW = dq_entry_width(ADDR_WIDTH, INST_WIDTH, GHR_WIDTH);
  localparam int TK_BIT = dq_taken_bit(GHR_WIDTH);
  localparam int INST_LSB = dq_inst_lsb(GHR_WIDTH);
  localparam int PC_LSB = dq_pc_lsb(INST_WIDTH, GHR_WIDTH);
  logic [PTR_W-1:0] head, tail, occ, n_in_p, n_out_p, skip;
  logic [NI_W-1:0]  n_in;
  logic [NO_W-1:0]  n_vld;
  logic [EW-1:0]    mem [DEPTH];
  logic [EW-1:0]    in_ent [FETCH_WIDTH];
  logic             byp, wr_en;
  assign occ = tail - head;
  assign count = occ;
  // Readiness looks only at occupancy so there is no path from out_accept.
  assign in_ready = rst & (occ <= PTR_W'(DEPTH - FETCH_WIDTH));
  dq_prefix_count #(.WIDTH(FETCH_WIDTH)) u_n_in (.vec(in_valid), .cnt(n_in));
  dq_prefix_count #(.WIDTH(DECODE_WIDTH)) u_n_vld (.vec(out_valid), .cnt(n_vld));
  assign n_in_p = PTR_W'(n_in);
  assign n_out_p = (PTR_W'(out_accept) < PTR_W'(n_vld)) ? PTR_W'(out_accept) : PTR_W'(n_vld);
  assign wr_en = in_ready & (n_in != '0) & ~flush;
`ifdef DECODE_QUEUE_BYPASS_EN
  assign byp = (occ == '0) & ~flush & in_ready;
  assign skip = byp ? n_out_p : '0;
`else
  assign byp = 1'b0;
  assign skip = '0;
`endif
  genvar f, d;
  for (f = 0; f < FETCH_WIDTH; f++) begin : g_in
    assign in_ent[f] = {in_pc[f*ADDR_WIDTH +: ADDR_WIDTH], in_inst[f*INST_WIDTH +: INST_WIDTH],
                        in_taken[f], in_pht_index[f*GHR_WIDTH +: GHR_WIDTH]};
  end
  for (d = 0; d < DECODE_WIDTH; d++) begin : g_out
    logic [EW-1:0] e;
    logic          bv;
    if (d < FETCH_WIDTH) begin : g_byp
      assign e = byp ? in_ent[d] : mem[IDX_W'(head + PTR_W'(d))];
      assign bv = NI_W'(d) < n_in;
    end else begin : g_mem
      assign e = mem[IDX_W'(head + PTR_W'(d))];
      assign bv = 1'b0;
    end
    assign out_valid[d] = byp ? bv : (PTR_W'(d) < occ) & ~flush;
    assign out_pc[d*ADDR_WIDTH +: ADDR_WIDTH] = e[PC_LSB +: ADDR_WIDTH];
    assign out_inst[d*INST_WIDTH +: INST_WIDTH] = e[INST_LSB +: INST_WIDTH];
    assign out_taken[d] = e[TK_BIT];
    assign out_pht_index[d*GHR_WIDTH +: GHR_WIDTH] = e[GHR_WIDTH-1:0];
  end
  // Lanes already consumed through the bypass are skipped so tail stays packed.
  always_ff @(posedge clk) begin
    if (wr_en)
      for (int i = 0; i < FETCH_WIDTH; i++)
        if (PTR_W'(i) < n_in_p && PTR_W'(i) >= skip)
          mem[IDX_W'(tail + PTR_W'(i) - skip)] <= in_ent[i];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      head <= head + (byp ? '0 : n_out_p);
      tail <= tail + (wr_en ? n_in_p - skip : '0);
    end
  end
endmodule

// File: tb/tb_inst_decode_queue.sv
// tb_inst_decode_queue: queue-model scoreboard plus directed literal checks for inst_decode_queue.
module tb_inst_decode_queue;
  localparam int FW = 2, DW = 2, DEPTH = 8, AW = 32, IW = 32, GW = 5;
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;
    logic          tk;
    logic [GW-1:0] pht;
  } ent_t;
  logic clk = 0, rst = 0, flush = 0;
  logic [FW-1:0] in_valid = '0, in_taken = '0;
  logic [FW*AW-1:0] in_pc = '0;
  logic [FW*IW-1:0] in_inst = '0;
  logic [FW*GW-1:0] in_pht_index = '0;
  logic [1:0] out_accept = '0;
  logic in_ready;
  logic [DW-1:0] out_valid, out_taken;
  logic [DW*AW-1:0] out_pc;
  logic [DW*IW-1:0] out_inst;
  logic [DW*GW-1:0] out_pht_index;
  logic [3:0] count;
  ent_t q[$];
  int checks = 0, errors = 0;
  logic [31:0] pc_n = 32'h1000;
  inst_decode_queue #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(DEPTH),
                      .ADDR_WIDTH(AW), .INST_WIDTH(IW), .GHR_WIDTH(GW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
    .in_inst(in_inst), .in_taken(in_taken), .in_pht_index(in_pht_index),
    .in_ready(in_ready), .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_taken(out_taken), .out_pht_index(out_pht_index), .out_accept(out_accept),
    .count(count));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int n_in_f();
    int n = 0;
    while (n < FW && in_valid[n]) n++;
    return n;
  endfunction
  function automatic ent_t lane(input int i);
    ent_t e;
    e.pc = in_pc[i*AW +: AW];
    e.inst = in_inst[i*IW +: IW];
    e.tk = in_taken[i];
    e.pht = in_pht_index[i*GW +: GW];
    return e;
  endfunction
  function automatic bit ready_f();
    return rst && q.size() <= DEPTH - FW;
  endfunction
  function automatic bit byp_f();
`ifdef DECODE_QUEUE_BYPASS_EN
    return q.size() == 0 && !flush && ready_f();
`else
    return 1'b0;
`endif
  endfunction
  function automatic int nvis_f();
    int n;
    if (!rst || flush) return 0;
    n = byp_f() ? n_in_f() : q.size();
    return n < DW ? n : DW;
  endfunction
  function automatic ent_t vis(input int i);
    return byp_f() ? lane(i) : q[i];
  endfunction
  always @(negedge rst) q.delete();
  always @(posedge clk) begin
    int nv, no, ni;
    bit rdy, bp;
    if (!rst || flush) q.delete();
    else begin
      rdy = ready_f();
      bp = byp_f();
      ni = n_in_f();
      nv = nvis_f();
      no = out_accept < nv ? int'(out_accept) : nv;
      if (bp) begin
        for (int i = no; i < ni; i++) q.push_back(lane(i));
      end else begin
        for (int i = 0; i < no; i++) void'(q.pop_front());
        if (rdy) for (int i = 0; i < ni; i++) q.push_back(lane(i));
      end
    end
  end
  always @(negedge clk) begin
    int nv;
    ent_t e;
    nv = nvis_f();
    chk("in_ready", in_ready, ready_f());
    chk("count", count, q.size());
    for (int i = 0; i < DW; i++) begin
      chk("out_valid", out_valid[i], i < nv);
      if (i < nv) begin
        e = vis(i);
        chk("out_pc", out_pc[i*AW +: AW], e.pc);
        chk("out_inst", out_inst[i*IW +: IW], e.inst);
        chk("out_taken", out_taken[i], e.tk);
        chk("out_pht", out_pht_index[i*GW +: GW], e.pht);
      end
    end
  end
  task automatic put(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                     input logic [1:0] acc, input logic fl);
    in_valid = v;
    in_pc = {p1, p0};
    in_inst = {~p1, ~p0};
    in_taken = {p1[2], p0[2]};
    in_pht_index = {p1[6:2], p0[6:2]};
    out_accept = acc;
    flush = fl;
  endtask
  task automatic feed(input logic [1:0] acc);
    put(2'b11, pc_n, pc_n + 32'd4, acc, 1'b0);
    pc_n += 32'd8;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input logic [1:0] acc);
    put(2'b00, 32'h0, 32'h0, acc, 1'b0);
  endtask
  initial begin
    tick();
    tick();
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_count", count, 4'd0);
    chk("rst_valid", out_valid, 2'b00);
    rst = 1;
    #1;
    chk("rel_ready", in_ready, 1'b1);
    chk("rel_count", count, 4'd0);
    chk("rel_valid", out_valid, 2'b00);
    feed(2'd0);
    tick();
    idle(2'd0);
    #1;
    chk("enq_valid", out_valid, 2'b11);
    chk("enq_pc0", out_pc[31:0], 32'h1000);
    chk("enq_pc1", out_pc[63:32], 32'h1004);
    chk("enq_count", count, 4'd2);
    for (int i = 0; i < 4; i++) begin
      feed(2'd0);
      tick();
    end
    idle(2'd0);
    #1;
    chk("full_count", count, 4'd8);
    chk("full_ready", in_ready, 1'b0);
    idle(2'd1);
    tick();
    idle(2'd0);
    #1;
    chk("pop1_count", count, 4'd7);
    chk("pop1_ready", in_ready, 1'b0);
    idle(2'd2);
    repeat (4) tick();
    idle(2'd0);
    #1;
    chk("drain_count", count, 4'd0);
    for (int i = 0; i < 20; i++) begin
      feed(2'd2);
      tick();
    end
    idle(2'd0);
    #1;
`ifdef DECODE_QUEUE_BYPASS_EN
    chk("steady_count", count, 4'd0);
`else
    chk("steady_count", count, 4'd2);
`endif
    idle(2'd2);
    repeat (2) tick();
    put(2'b10, 32'h2000, 32'h2004, 2'd0, 1'b0);
    tick();
    idle(2'd0);
    #1;
    chk("hole_count", count, 4'd0);
    put(2'b01, 32'h3000, 32'h3004, 2'd0, 1'b0);
    tick();
    idle(2'd0);
    #1;
    chk("one_count", count, 4'd1);
    chk("one_pc", out_pc[31:0], 32'h3000);
    feed(2'd0);
    tick();
    feed(2'd0);
    tick();
    idle(2'd0);
    #1;
    chk("five_count", count, 4'd5);
    put(2'b11, 32'hdead0000, 32'hdead0004, 2'd2, 1'b1);
    #1;
    chk("flush_valid", out_valid, 2'b00);
    tick();
    idle(2'd0);
    #1;
    chk("flush_count", count, 4'd0);
    chk("flush_novalid", out_valid, 2'b00);
    for (int i = 0; i < 3; i++) begin
      feed(2'd1);
      tick();
    end
    idle(2'd0);
    #2;
    rst = 0;
    #1;
    chk("async_count", count, 4'd0);
    chk("async_ready", in_ready, 1'b0);
    tick();
    rst = 1;
    tick();
`ifdef DECODE_QUEUE_BYPASS_EN
    put(2'b11, 32'h4000, 32'h4004, 2'd2, 1'b0);
    #1;
    chk("byp_valid", out_valid, 2'b11);
    chk("byp_pc", out_pc, {32'h4004, 32'h4000});
    tick();
    idle(2'd0);
    #1;
    chk("byp_count", count, 4'd0);
`endif
    feed(2'd1);
    tick();
    feed(2'd2);
    tick();
    idle(2'd2);
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
